aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Iterative AES-128 encryption controller; it owns the 128-bit state register.
- Feeds one round datapath (SubBytes/ShiftRows/MixColumns, fixed pipeline latency) ten times per block and performs AddRoundKey itself.
- Sits between an upstream valid/ready block source and a downstream ciphertext sink.
- Fetches round keys by index from a separate key-expansion store.

Parameters:
- DP_LAT, 2, pipeline latency of the round datapath in clock edges (legal 0..7)
- NR, 10, number of rounds (fixed 10 for AES-128; no other value supported)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low
- in_valid  input  1  plaintext block offered
- in_ready  output  1  sequencer can accept a block
- in_data  input  128  plaintext, byte 0 in [127:120]
- rk_idx  output  4  round-key index requested (0..10)
- rk_in  input  128  round key for rk_idx, combinational from key store
- dp_in  output  128  state presented to round datapath
- dp_last  output  1  final round: datapath must bypass MixColumns
- dp_out  input  128  round datapath result, DP_LAT edges after dp_in
- out_valid  output  1  ciphertext available
- out_ready  input  1  sink accepts ciphertext
- out_data  output  128  ciphertext (the state register)
- busy  output  1  block in flight (RUN or DONE)

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst=0, asynchronous) forces:
  - state IDLE, state register 0, round counter 0, wait counter 0
  - in_ready=0 while rst is low, in_ready=1 from the first clock after release
  - out_valid=0, busy=0, dp_last=0, rk_idx=0
- IDLE:
  - in_ready=1, rk_idx=0.
  - On in_valid & in_ready: state_reg <= in_data ^ rk_in (AddRoundKey 0), round <= 1, wcnt <= 0, go to RUN.
- RUN:
  - dp_in = state_reg (continuously, in every state).
  - rk_idx = round; dp_last = (round==NR).
  - wcnt counts 0..DP_LAT, one per cycle.
  - When wcnt==DP_LAT: state_reg <= dp_out ^ rk_in, wcnt <= 0.
    - If round==NR, go to DONE.
    - Otherwise round <= round+1.
  - The state register is held stable for all DP_LAT+1 cycles of a round.
- Round timing: each round occupies DP_LAT+1 cycles; DP_LAT=0 is a combinational datapath (1 cycle/round).
- Latency: out_valid rises exactly NR*(DP_LAT+1) cycles after the accept edge (30 cycles at the default DP_LAT=2).
- DONE:
  - out_valid=1, out_data=state_reg, both stable until out_ready.
  - On out_valid & out_ready: go to IDLE; out_valid drops the next cycle.
  - A new block is accepted only once back in IDLE; no overlap, one bubble cycle minimum between blocks.
- in_ready=0 in RUN and DONE. in_valid in those states is ignored; upstream holds its data.
- busy = (state != IDLE).
- rk_idx never exceeds NR.
- Round counter is 4-bit and never wraps; returns to 0 on entry to IDLE.
- Reset asserted mid-RUN or mid-DONE aborts the block immediately. No output is produced and state_reg is cleared.
- out_ready asserted while not out_valid has no effect.

Optional Feature:
- Macro: AES_SEQ_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort=1 in RUN or DONE returns to IDLE on the next edge, clears state_reg, and never asserts out_valid for that block.
  - abort in IDLE is ignored.
  - If abort and out_ready arrive in the same DONE cycle, out_ready wins: the transfer completes.
- When not defined: no abort port; a block can only be terminated by rst.

Test Plan:
- FIPS-197 C.1 vector, DP_LAT=2, behavioural round model plus key table:
  - key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff
  - -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a
  - -> out_valid exactly 30 cycles after accept
  - -> rk_idx sequence 0,1..10, each index held 3 cycles; dp_last high only during round 10
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid and out_data stable, in_ready=0 throughout; accept completes on the first out_ready=1 cycle.
- Back-to-back: two blocks with in_valid held high and out_ready=1 -> second accept occurs in the first IDLE cycle after the first output transfer; both ciphertexts correct.
- Reset mid-operation: drive rst=0 during round 5 -> same cycle outputs in_ready=0, out_valid=0, busy=0, rk_idx=0; after release a fresh block encrypts correctly.
- DP_LAT=0 build: C.1 vector -> same ciphertext, out_valid 10 cycles after accept.
- With AES_SEQ_ABORT_EN: abort during round 3 -> IDLE next cycle, no out_valid pulse ever for that block; abort coinciding with out_ready in DONE -> transfer observed.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//
// Iterative AES-128 encryption controller. It owns the 128-bit state
// register and steps one block through ten rounds of an external round
// datapath (SubBytes/ShiftRows/MixColumns with a fixed pipeline latency).
// AddRoundKey is done here by XORing with the round key fetched by index
// from an external key-expansion store.
//
// Parameters:
//   DP_LAT  pipeline latency of the round datapath in clock edges (0..7)
//   NR      number of rounds; AES-128 only, so this must stay 10
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   plaintext block offered by upstream
//   in_ready   sequencer can accept a block (IDLE, and clocked since reset)
//   in_data    plaintext, byte 0 in [127:120]
//   rk_idx     round-key index requested (0..NR)
//   rk_in      round key for rk_idx, combinational from the key store
//   dp_in      state presented to the round datapath (the state register)
//   dp_last    final round: datapath must bypass MixColumns
//   dp_out     round datapath result, DP_LAT edges after dp_in
//   out_valid  ciphertext available
//   out_ready  sink accepts ciphertext
//   out_data   ciphertext (the state register)
//   busy       block in flight (RUN or DONE)
//   abort      (only with AES_SEQ_ABORT_EN) drop the block in flight
//
// Optional feature macro: AES_SEQ_ABORT_EN adds the abort input. Without
// it a block can only be terminated by rst.

module aes_round_sequencer #(
  parameter int DP_LAT = 2,
  parameter int NR     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic [127:0] dp_in,
  output logic         dp_last,
  input  logic [127:0] dp_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
`ifdef AES_SEQ_ABORT_EN
  ,
  input  logic         abort
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(DP_LAT);
  localparam logic [3:0] LAST_RND  = 4'(NR);

  state_t         state_q, state_d;
  logic [127:0]   data_q, data_d;
  logic [3:0]     round_q, round_d;
  logic [2:0]     wcnt_q, wcnt_d;
  logic           armed_q;

  // State, data and counters. armed_q keeps in_ready low until the first
  // clock edge after reset release, so no block is taken during release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      round_q <= '0;
      wcnt_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      round_q <= round_d;
      wcnt_q  <= wcnt_d;
      armed_q <= 1'b1;
    end
  end

  // Next-state logic. The state register only changes on accept (key 0
  // mix) and on the last wait cycle of each round, so dp_in stays stable
  // for the whole DP_LAT+1 cycles the datapath needs.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    round_d = round_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && armed_q) begin
          data_d  = in_data ^ rk_in;
          round_d = 4'd1;
          wcnt_d  = 3'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (wcnt_q == WAIT_LAST) begin
          data_d = dp_out ^ rk_in;
          wcnt_d = 3'd0;
          if (round_q == LAST_RND) begin
            state_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
          end
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          round_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = 4'd0;
        wcnt_d  = 3'd0;
      end
    endcase
`ifdef AES_SEQ_ABORT_EN
    // A completing output transfer takes priority over abort.
    if (abort && (state_q != IDLE) && !((state_q == DONE) && out_ready)) begin
      state_d = IDLE;
      data_d  = '0;
      round_d = 4'd0;
      wcnt_d  = 3'd0;
    end
`endif
  end

  // round_q is 0 in IDLE, so it doubles as the key index in every state.
  assign in_ready  = (state_q == IDLE) && armed_q;
  assign rk_idx    = round_q;
  assign dp_in     = data_q;
  assign dp_last   = (state_q == RUN) && (round_q == LAST_RND);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer
//
// Bench for aes_round_sequencer. Two instances share clock and reset:
// dut0 with DP_LAT=2 (registered datapath model) and dut1 with DP_LAT=0
// (combinational datapath model). The bench supplies a behavioural AES
// round function and the FIPS-197 C.1 key schedule as the key store.

module tb_aes_round_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] inData;
  logic         inValid;
  logic         outReady;
  logic         useFast;

  logic         in_ready0, in_ready1, out_valid0, out_valid1;
  logic         busy0, busy1, dp_last0, dp_last1;
  logic [3:0]   rk_idx0, rk_idx1;
  logic [127:0] rk_in0, rk_in1, dp_in0, dp_in1, dp_out0, dp_out1;
  logic [127:0] out_data0, out_data1;
  logic [127:0] pipeA, pipeB;
`ifdef AES_SEQ_ABORT_EN
  logic         abort0;
`endif

  logic         curInReady, curOutValid, curBusy, curDpLast;
  logic [3:0]   curRkIdx;
  logic [127:0] curOutData;

  int vecCount  = 0;
  int missCount = 0;

  // FIPS-197 C.1 expanded key for key 000102...0e0f
  logic [127:0] rkTable [0:10] = '{
    128'h000102030405060708090a0b0c0d0e0f,
    128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe,
    128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd,
    128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b,
    128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2,
    128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5
  };

  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // GF(2^8) arithmetic and the AES round, computed from first principles
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box: multiplicative inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, s;
    r = 8'h01; s = x;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aesRound(input logic [127:0] s, input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) t[rr+4*c] = b[rr+4*((c+rr)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r;
  endfunction

  function automatic logic [127:0] aesEncrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rkTable[0];
    for (int r = 1; r <= 10; r++) s = aesRound(s, r == 10) ^ rkTable[r];
    return s;
  endfunction

  // Key store and datapath models
  assign rk_in0  = rkTable[rk_idx0];
  assign rk_in1  = rkTable[rk_idx1];
  assign dp_out1 = aesRound(dp_in1, dp_last1);
  assign dp_out0 = pipeB;

  always @(posedge clk) begin
    pipeA <= aesRound(dp_in0, dp_last0);
    pipeB <= pipeA;
  end

  always #5 clk = ~clk;

  aes_round_sequencer #(.DP_LAT(2), .NR(10)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(inValid & ~useFast), .in_ready(in_ready0), .in_data(inData),
    .rk_idx(rk_idx0), .rk_in(rk_in0),
    .dp_in(dp_in0), .dp_last(dp_last0), .dp_out(dp_out0),
    .out_valid(out_valid0), .out_ready(outReady & ~useFast), .out_data(out_data0),
    .busy(busy0)
`ifdef AES_SEQ_ABORT_EN
    , .abort(abort0)
`endif
  );

  aes_round_sequencer #(.DP_LAT(0), .NR(10)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(inValid & useFast), .in_ready(in_ready1), .in_data(inData),
    .rk_idx(rk_idx1), .rk_in(rk_in1),
    .dp_in(dp_in1), .dp_last(dp_last1), .dp_out(dp_out1),
    .out_valid(out_valid1), .out_ready(outReady & useFast), .out_data(out_data1),
    .busy(busy1)
`ifdef AES_SEQ_ABORT_EN
    , .abort(1'b0)
`endif
  );

  // Outputs of whichever instance the current test is driving
  assign curInReady  = useFast ? in_ready1  : in_ready0;
  assign curOutValid = useFast ? out_valid1 : out_valid0;
  assign curOutData  = useFast ? out_data1  : out_data0;
  assign curBusy     = useFast ? busy1      : busy0;
  assign curRkIdx    = useFast ? rk_idx1    : rk_idx0;
  assign curDpLast   = useFast ? dp_last1   : dp_last0;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] ct;
    bit           fast;
    int           lat;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    vecCount++;
    missCount++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a block, wait for accept, then count edges until out_valid.
  // With checkSeq the key index, dp_last and handshake outputs are checked
  // every cycle of the run (DP_LAT=2: each round is 3 cycles).
  task automatic applyStimulus(input logic [127:0] pt, input bit fast, input bit checkSeq,
                               output logic [127:0] ct, output int lat);
    int guard;
    useFast = fast;
    inData = pt;
    inValid = 1'b1;
    outReady = 1'b0;
    guard = 0;
    while (curInReady !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) timeoutFail("acceptWait");
    if (checkSeq) checkOutput("idleRkIdx", 128'(curRkIdx), 128'd0);
    tick();
    inValid = 1'b0;
    lat = 0;
    while (curOutValid !== 1'b1 && lat < 100) begin
      if (checkSeq) begin
        checkOutput("rkIdx", 128'(curRkIdx), 128'(lat / 3 + 1));
        checkOutput("dpLast", 128'(curDpLast), 128'((lat / 3 + 1) == 10));
        checkOutput("busyInReady", 128'({curBusy, curInReady}), 128'(2'b10));
      end
      tick();
      lat++;
    end
    ct = curOutData;
  endtask

  task automatic finishBlock();
    outReady = 1'b1;
    tick();
    checkOutput("validDrop", 128'({curOutValid, curBusy}), 128'(2'b00));
    outReady = 1'b0;
    tick();
  endtask

  initial begin
    logic [127:0] ct, ct1, pt2;
    int lat, hits;

    rst = 1'b0;
    inValid = 1'b0;
    outReady = 1'b0;
    useFast = 1'b0;
    inData = '0;
`ifdef AES_SEQ_ABORT_EN
    abort0 = 1'b0;
`endif

    vecs[0] = '{C1_PT, C1_CT, 1'b0, 30};
    vecs[1] = '{128'h0, aesEncrypt(128'h0), 1'b0, 30};
    vecs[2] = '{{128{1'b1}}, aesEncrypt({128{1'b1}}), 1'b0, 30};
    vecs[3] = '{128'h3243f6a8885a308d313198a2e0370734,
                aesEncrypt(128'h3243f6a8885a308d313198a2e0370734), 1'b0, 30};
    vecs[4] = '{C1_PT, C1_CT, 1'b1, 10};
    vecs[5] = '{128'h0123456789abcdeffedcba9876543210,
                aesEncrypt(128'h0123456789abcdeffedcba9876543210), 1'b1, 10};

    // Reset state, including in_ready held low until the first edge after release
    #3;
    checkOutput("rstOutputs0", 128'({in_ready0, out_valid0, busy0, dp_last0, rk_idx0}), 128'd0);
    checkOutput("rstData0", out_data0, 128'd0);
    checkOutput("rstOutputs1", 128'({in_ready1, out_valid1, busy1}), 128'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("readyBeforeEdge", 128'(in_ready0), 128'd0);
    tick();
    checkOutput("readyAfterEdge", 128'(in_ready0), 128'd1);

    // Table-driven encryptions for both datapath latencies
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].pt, vecs[i].fast, i == 0, ct, lat);
      checkOutput($sformatf("ct[%0d]", i), ct, vecs[i].ct);
      checkOutput($sformatf("lat[%0d]", i), 128'(lat), 128'(vecs[i].lat));
      finishBlock();
    end

    // Backpressure: DONE held for 20 cycles, new offers ignored meanwhile
    applyStimulus(C1_PT, 1'b0, 1'b0, ct, lat);
    inValid = 1'b1;
    inData = 128'hdeadbeef;
    hits = 0;
    for (int n = 0; n < 20; n++) begin
      if (curOutValid !== 1'b1 || curOutData !== C1_CT || curInReady !== 1'b0) hits++;
      tick();
    end
    inValid = 1'b0;
    checkOutput("bpUnstableCycles", 128'(hits), 128'd0);
    checkOutput("bpData", curOutData, C1_CT);
    outReady = 1'b1;
    tick();
    checkOutput("bpRelease", 128'({curOutValid, curInReady}), 128'(2'b01));
    outReady = 1'b0;
    tick();

    // Back-to-back: second accept in the first IDLE cycle after the transfer
    pt2 = 128'h00000000000000000000000000000001;
    useFast = 1'b0;
    inData = C1_PT;
    inValid = 1'b1;
    outReady = 1'b1;
    tick();
    inData = pt2;
    for (int n = 1; n <= 62; n++) begin
      tick();
      if (n == 29) checkOutput("b2bEarly", 128'(curOutValid), 128'd0);
      if (n == 30) checkOutput("b2bCt1", curOutData, C1_CT);
      if (n == 30) checkOutput("b2bValid1", 128'(curOutValid), 128'd1);
      if (n == 31) checkOutput("b2bIdle", 128'({curInReady, curOutValid, curBusy}), 128'(3'b100));
      if (n == 32) begin
        checkOutput("b2bAccept2", 128'({curInReady, curBusy}), 128'(2'b01));
        inValid = 1'b0;
      end
      if (n == 61) checkOutput("b2bEarly2", 128'(curOutValid), 128'd0);
      if (n == 62) checkOutput("b2bValid2", 128'(curOutValid), 128'd1);
      if (n == 62) checkOutput("b2bCt2", curOutData, aesEncrypt(pt2));
    end
    tick();
    outReady = 1'b0;
    checkOutput("b2bDone", 128'(curBusy), 128'd0);
    tick();

    // Reset during round 5 aborts the block immediately
    inData = C1_PT;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    for (int n = 1; n <= 13; n++) tick();
    checkOutput("midRound5", 128'(curRkIdx), 128'd5);
    rst = 1'b0;
    #1;
    checkOutput("midRstOutputs", 128'({curInReady, curOutValid, curBusy, curRkIdx}), 128'd0);
    checkOutput("midRstData", curOutData, 128'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    applyStimulus(vecs[3].pt, 1'b0, 1'b0, ct, lat);
    checkOutput("postRstCt", ct, vecs[3].ct);
    checkOutput("postRstLat", 128'(lat), 128'd30);
    finishBlock();

`ifdef AES_SEQ_ABORT_EN
    // Abort in round 3: IDLE next cycle, no output ever for that block
    useFast = 1'b0;
    inData = C1_PT;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    for (int n = 1; n <= 7; n++) tick();
    checkOutput("abortRound3", 128'(curRkIdx), 128'd3);
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    checkOutput("abortIdle", 128'({curInReady, curOutValid, curBusy}), 128'(3'b100));
    checkOutput("abortData", curOutData, 128'd0);
    hits = 0;
    for (int n = 0; n < 40; n++) begin
      if (curOutValid === 1'b1) hits++;
      tick();
    end
    checkOutput("abortNoValid", 128'(hits), 128'd0);

    // Abort in IDLE is ignored
    abort0 = 1'b1;
    tick();
    checkOutput("abortInIdle", 128'({curInReady, curBusy}), 128'(2'b10));
    abort0 = 1'b0;

    // Abort together with out_ready in DONE: the transfer completes
    applyStimulus(C1_PT, 1'b0, 1'b0, ct, lat);
    abort0 = 1'b1;
    outReady = 1'b1;
    #1;
    checkOutput("abortXferValid", 128'(curOutValid), 128'd1);
    checkOutput("abortXferCt", curOutData, C1_CT);
    tick();
    abort0 = 1'b0;
    outReady = 1'b0;
    checkOutput("abortXferIdle", 128'({curOutValid, curBusy}), 128'd0);
    checkOutput("abortXferKept", curOutData, C1_CT);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
